// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter for the shared system bus.
// The grant is held until done, until the owner drops its request, or until
// the watchdog expires. A single RELEASE cycle of turnaround separates grants.
module bus_arbiter #(
  parameter int unsigned SLAVE_LEN   = 2,
  parameter int unsigned TIMEOUT_LEN = 8,
  parameter int unsigned TIMEOUT     = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_m1,
  input  logic                 req_m2,
  input  logic [SLAVE_LEN-1:0] slave_select_m1,
  input  logic [SLAVE_LEN-1:0] slave_select_m2,
  input  logic                 done,
  output logic                 grant_m1,
  output logic                 grant_m2,
  output logic                 master_sel,
  output logic [SLAVE_LEN-1:0] slave_sel,
  output logic                 bus_busy,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // A zero TIMEOUT turns the watchdog off entirely.
  localparam bit                     WdogEn      = (TIMEOUT != 0);
  localparam logic [TIMEOUT_LEN-1:0] TimeoutLast =
    TIMEOUT_LEN'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t                 state_q,     state_d;
  logic [TIMEOUT_LEN-1:0] cnt_q,       cnt_d;
  logic                   prio_q,      prio_d;
  logic                   grantM1_q,   grantM1_d;
  logic                   grantM2_q,   grantM2_d;
  logic                   masterSel_q, masterSel_d;
  logic [SLAVE_LEN-1:0]   slaveSel_q,  slaveSel_d;
  logic                   busBusy_q,   busBusy_d;
  logic                   timeout_q,   timeout_d;
  logic                   grantedReq;

  // Request line of whichever master currently owns the bus.
  assign grantedReq = masterSel_q ? req_m2 : req_m1;

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    grantM1_d   = 1'b0;
    grantM2_d   = 1'b0;
    masterSel_d = masterSel_q;
    slaveSel_d  = slaveSel_q;
    busBusy_d   = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_m1 && (!req_m2 || !prio_q)) begin
          state_d     = BUSY;
          grantM1_d   = 1'b1;
          masterSel_d = 1'b0;
          slaveSel_d  = slave_select_m1;
          busBusy_d   = 1'b1;
          cnt_d       = '0;
          prio_d      = 1'b1;
        end else if (req_m2) begin
          state_d     = BUSY;
          grantM2_d   = 1'b1;
          masterSel_d = 1'b1;
          slaveSel_d  = slave_select_m2;
          busBusy_d   = 1'b1;
          cnt_d       = '0;
          prio_d      = 1'b0;
        end
      end

      BUSY: begin
        if (done || !grantedReq) begin
          state_d = RELEASE;
        end else if (WdogEn && (cnt_q == TimeoutLast)) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end else begin
          grantM1_d = grantM1_q;
          grantM2_d = grantM2_q;
          busBusy_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + TIMEOUT_LEN'(1);
          end
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      grantM1_q   <= 1'b0;
      grantM2_q   <= 1'b0;
      masterSel_q <= 1'b0;
      slaveSel_q  <= '0;
      busBusy_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      grantM1_q   <= grantM1_d;
      grantM2_q   <= grantM2_d;
      masterSel_q <= masterSel_d;
      slaveSel_q  <= slaveSel_d;
      busBusy_q   <= busBusy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant_m1   = grantM1_q;
  assign grant_m2   = grantM2_q;
  assign master_sel = masterSel_q;
  assign slave_sel  = slaveSel_q;
  assign bus_busy   = busBusy_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the shared system bus. Master 1 and master 2 request the bus, and the arbiter grants it to one master at a time. The grant is held until the transaction completes, the requester withdraws, or a watchdog timeout fires. Ties are resolved round-robin. The arbiter also drives the master-select and slave-select mux controls for the bus datapath.

## Interface
- SLAVE_LEN, 2, width of the slave-select field.
- TIMEOUT_LEN, 8, width of the watchdog counter.
- TIMEOUT, 200, number of BUSY cycles before a forced release. 0 disables the watchdog.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- req_m1  in  1  bus request from master 1; level, held for the whole transaction.
- req_m2  in  1  bus request from master 2; level, held for the whole transaction.
- slave_select_m1  in  SLAVE_LEN  target slave of master 1.
- slave_select_m2  in  SLAVE_LEN  target slave of master 2.
- done  in  1  transaction-complete strobe (OR of tx_done/rx_done of the granted master).
- grant_m1  out  1  master 1 owns the bus.
- grant_m2  out  1  master 2 owns the bus.
- master_sel  out  1  datapath mux select: 0 = master 1, 1 = master 2. Holds its value when idle.
- slave_sel  out  SLAVE_LEN  slave select latched from the winner at grant time.
- bus_busy  out  1  high in the BUSY state.
- timeout  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- FSM states: IDLE, BUSY, RELEASE. All outputs are registered.
- **IDLE**
  - Only one request high: grant that master.
  - Both requests high: grant the master indicated by the priority pointer `prio` (0 → m1, 1 → m2).
  - No request: stay in IDLE.
  - On a grant: go to BUSY, set the matching grant, set master_sel, latch slave_sel from the winner's slave_select.
  - Also on a grant: clear the watchdog counter, and set `prio` to point at the other master (winner m1 → prio = 1; winner m2 → prio = 0).
- **BUSY** (grant held; bus_busy = 1). Exit conditions in priority order:
  - done = 1: go to RELEASE.
  - Granted master's req = 0 (abandon): go to RELEASE, no timeout.
  - TIMEOUT ≠ 0 and counter == TIMEOUT-1: go to RELEASE and assert timeout for the RELEASE cycle.
  - Otherwise: increment the counter and stay in BUSY.
- **RELEASE**
  - Both grants low, bus_busy low; master_sel and slave_sel unchanged.
  - Always go to IDLE next cycle (one-cycle bus turnaround).
- **Counter**: TIMEOUT_LEN bits, saturating, never wraps. TIMEOUT must be < 2^TIMEOUT_LEN.
- **Ignored inputs**: slave_select inputs are ignored after the grant. The non-granted master's req is ignored in BUSY and RELEASE.
- **Invariant**: grant_m1 & grant_m2 is never 1.
- **Reset** (reset = 0, any state, takes effect immediately): state IDLE, grants 0, master_sel 0, slave_sel 0, bus_busy 0, timeout 0, counter 0, prio 0. Reset asserted mid-transaction drops the grant without a RELEASE cycle.

## Timing
- **Request to grant**
  - req sampled high at edge E → grant, master_sel, slave_sel and bus_busy valid after E.
  - Latency is 1 cycle.
- **Completion to release**
  - done sampled high at edge D → grant low after D (RELEASE).
  - IDLE after D+1.
  - Earliest new grant after D+2.
  - Minimum gap between grants is 2 cycles.
- **Watchdog release**: with TIMEOUT = T and no done, the grant is high for exactly T cycles. timeout pulses in cycle T+1 after the grant edge.
- **done and watchdog in the same cycle**: done wins; no timeout pulse.
- **done outside BUSY**: no effect.
- **Back-to-back contention**: with both masters requesting continuously, grants alternate m1, m2, m1, … with 2 idle cycles between them.

## Test plan
- **Reset**: reset = 0 mid-BUSY → grants, bus_busy and timeout go to 0 immediately. After release, both masters requesting → m1 granted first (prio = 0).
- **Single master**: req_m1 = 1, slave_select_m1 = 2'b10 → grant_m1 = 1, master_sel = 0, slave_sel = 2'b10 one cycle later. done after 5 cycles → grant_m1 = 0 next cycle. slave_sel stays 2'b10.
- **Round-robin**: req_m1 = req_m2 = 1 held, done pulsed every 4th BUSY cycle → grant sequence m1, m2, m1, m2. master_sel toggles 0, 1, 0, 1. Never both grants high.
- **Watchdog**: TIMEOUT = 10, req_m2 = 1, no done → grant_m2 high for exactly 10 cycles, timeout = 1 for 1 cycle, then IDLE. With req_m2 still high, re-grant 2 cycles after the release.
- **Abandon**: grant_m1 high, req_m1 dropped at cycle 3 → RELEASE next cycle, timeout stays 0. A pending req_m2 is granted 2 cycles later.
- **Simultaneous done and watchdog**: TIMEOUT = 4, done = 1 in the 4th BUSY cycle → release with timeout = 0. slave_select_m1 changing during BUSY → slave_sel unchanged.
